// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit framer and the PWM
// diagnostic stage that sits downstream of it.
//   state_t     : framer FSM state encoding
//   DCNT_*      : bit-index codes exported on data_cnt_o (0..7 are data bits)
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] DCNT_START = 4'd8;
  localparam logic [3:0] DCNT_STOP  = 4'd9;
  localparam logic [3:0] DCNT_PAR   = 4'd10;
  localparam logic [3:0] DCNT_IDLE  = 4'd15;

endpackage

// File: rtl/uart_tx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_if
// Byte-producer handshake into the UART transmit framer.
//   tx_data  : byte to send, held by the producer until accepted
//   tx_valid : producer has a byte on tx_data
//   tx_ready : framer takes the byte on a cycle where valid & ready
// Modports: master = producer side, slave = framer side.
// ---------------------------------------------------------------------------
interface uart_tx_frame_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Per-bit baud counter for the UART framer.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : count while high, hold at 0 while low
//   cnt        : position inside the current bit period, 0..KBAUD-1
//   tick       : high on the last cycle of a bit period (cnt == KBAUD-1)
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int KBAUD    = 10416,
  parameter int CNT_BITS = $clog2(KBAUD)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic [CNT_BITS-1:0] cnt,
  output logic                tick
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(KBAUD - 1);

  assign tick = (cnt == CNT_LAST);

  // Wrap on every bit boundary so the next bit starts at 0 on the same edge
  // the framer changes tx and the bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// UART transmit framer: takes one byte per valid/ready handshake and sends
// it LSB-first as start, 8 data bits, [parity], stop at KBAUD clocks per bit.
// Optional even parity bit is built in when UART_TX_PARITY_EN is defined.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : tx_data / tx_valid / tx_ready byte handshake
//   tx           : serial line, idle high
//   busy         : high while a frame is on the line
//   baud_cnt_o   : position inside the current bit, 0..KBAUD-1
//   data_cnt_o   : bit index (0..7 data, 8 start, 9 stop, 10 parity, 15 idle)
// ---------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int KBAUD    = 10416,
  parameter int CNT_BITS = $clog2(KBAUD)
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_frame_if.slave      bus,
  output logic                tx,
  output logic                busy,
  output logic [CNT_BITS-1:0] baud_cnt_o,
  output logic [3:0]          data_cnt_o
);

  localparam logic [CNT_BITS-1:0] CNT_PRELAST = CNT_BITS'(KBAUD - 2);

  state_t     state;
  logic [7:0] shift_reg;
  logic       tick;
  logic       run;
  logic       accept;
`ifdef UART_TX_PARITY_EN
  logic       parity_bit;
`endif

  assign run    = (state != IDLE);
  assign accept = bus.tx_valid & bus.tx_ready;

  uart_baud_gen #(
    .KBAUD   (KBAUD),
    .CNT_BITS(CNT_BITS)
  ) u_baud_gen (
    .clk (clk),
    .rst_n(rst_n),
    .run (run),
    .cnt (baud_cnt_o),
    .tick(tick)
  );

  // Framer FSM. All outputs are registered here; tx_ready is precomputed
  // one cycle early so it is high in IDLE and on the final stop-bit cycle,
  // which is what allows back-to-back frames with no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      bus.tx_ready <= 1'b1;
      data_cnt_o   <= DCNT_IDLE;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= START;
            shift_reg    <= bus.tx_data;
            tx           <= 1'b0;
            busy         <= 1'b1;
            bus.tx_ready <= 1'b0;
            data_cnt_o   <= DCNT_START;
`ifdef UART_TX_PARITY_EN
            parity_bit   <= ^bus.tx_data;
`endif
          end
        end

        START: begin
          if (tick) begin
            state      <= DATA;
            tx         <= shift_reg[0];
            data_cnt_o <= 4'd0;
          end
        end

        // tx always shows shift_reg[0]; on a boundary we shift and
        // present the next bit, which is shift_reg[1] before the shift.
        DATA: begin
          if (tick) begin
            if (data_cnt_o == 4'd7) begin
`ifdef UART_TX_PARITY_EN
              state      <= PARITY;
              tx         <= parity_bit;
              data_cnt_o <= DCNT_PAR;
`else
              state      <= STOP;
              tx         <= 1'b1;
              data_cnt_o <= DCNT_STOP;
`endif
            end else begin
              shift_reg  <= shift_reg >> 1;
              tx         <= shift_reg[1];
              data_cnt_o <= data_cnt_o + 4'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state      <= STOP;
            tx         <= 1'b1;
            data_cnt_o <= DCNT_STOP;
          end
        end
`endif

        STOP: begin
          if (!tick) begin
            bus.tx_ready <= (baud_cnt_o == CNT_PRELAST);
          end else if (accept) begin
            state        <= START;
            shift_reg    <= bus.tx_data;
            tx           <= 1'b0;
            busy         <= 1'b1;
            bus.tx_ready <= 1'b0;
            data_cnt_o   <= DCNT_START;
`ifdef UART_TX_PARITY_EN
            parity_bit   <= ^bus.tx_data;
`endif
          end else begin
            state        <= IDLE;
            tx           <= 1'b1;
            busy         <= 1'b0;
            bus.tx_ready <= 1'b1;
            data_cnt_o   <= DCNT_IDLE;
          end
        end

        default: begin
          state        <= IDLE;
          tx           <= 1'b1;
          busy         <= 1'b0;
          bus.tx_ready <= 1'b1;
          data_cnt_o   <= DCNT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmit framer: accepts one byte per valid/ready handshake and serialises it LSB-first as 8N1 (start, 8 data, stop) at a fixed clocks-per-bit rate. It is the stage directly upstream of the PWM diagnostic block, and it exports that block's two inputs: the per-bit baud counter and the bit-index counter. Those exports let the diagnostic PWM show the current frame position on a pin.

## Interface
- KBAUD, 10416, clocks per bit period; legal range 4..16383.
- CNT_BITS, $clog2(KBAUD), width of the baud counter.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send; sampled only on the accept cycle.
- tx_valid  in  1  producer holds tx_data valid.
- tx_ready  out  1  framer can accept a byte this cycle.
- tx  out  1  serial line, idle high.
- busy  out  1  high from the cycle after accept until the last stop-bit cycle.
- baud_cnt_o  out  CNT_BITS  position inside the current bit period, 0..KBAUD-1.
- data_cnt_o  out  4  bit index: 0..7 = data bits, 8 = start, 9 = stop, 10 = parity, 15 = idle.

## Operation
- States:
  - IDLE: tx=1, baud_cnt_o=0, data_cnt_o=15.
  - START: tx=0.
  - DATA: tx = shift_reg[0].
  - PARITY: present only with the macro.
  - STOP: tx=1.
- The baud counter runs 0..KBAUD-1 in every non-IDLE state and wraps to 0 on each bit boundary. It is held at 0 in IDLE.
- Transitions, each taken on the cycle where baud_cnt==KBAUD-1:
  - START -> DATA with data_cnt 0.
  - DATA increments data_cnt, shifts shift_reg right, and goes to PARITY or STOP after index 7.
  - PARITY -> STOP.
  - STOP -> IDLE, or -> START if a byte is accepted on that cycle.
- IDLE -> START on accept.
- Accept = tx_valid & tx_ready. tx_data is captured into shift_reg on the accept cycle.
- tx_ready = (state==IDLE) | (state==STOP & baud_cnt==KBAUD-1). This allows back-to-back frames with zero idle gap.
- tx_valid without tx_ready is ignored. The producer holds tx_data until accepted.
- Every output is registered. No combinational path from inputs to tx.

## Timing
- Reset values: tx=1, tx_ready=1, busy=0, baud_cnt_o=0, data_cnt_o=15, state IDLE.
- Accept on edge T: at T+1, tx=0, data_cnt_o=8, baud_cnt_o=0, busy=1.
- Each bit lasts exactly KBAUD cycles, so a frame is 10*KBAUD cycles (11*KBAUD with parity).
- baud_cnt_o and data_cnt_o change on the same edge as tx. At every bit boundary the diagnostic stage therefore sees baud_cnt_o==0 aligned with the new index.
- Back-to-back: the stop bit's last cycle is followed immediately by the next start bit; busy stays 1.
- Reset asserted mid-frame: tx returns to 1 asynchronously, the in-flight byte is discarded, and nothing is resumed after release.
- Reset deassertion: the first accept is possible on the first clock edge after rst_n rises.

## Configuration
- UART_TX_PARITY_EN defined:
  - An even-parity bit (XOR of the 8 data bits, computed at accept) is inserted between data bit 7 and stop.
  - data_cnt_o=10 during the parity bit.
  - Frame length is 11*KBAUD.
- Undefined: no PARITY state, the frame is 8N1, and code 10 never appears.

## Structure
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - Constants DCNT_START=4'd8, DCNT_STOP=4'd9, DCNT_PAR=4'd10, DCNT_IDLE=4'd15.
  - The diagnostic stage imports these same constants.
- Sub-module uart_baud_gen:
  - Parameterised by KBAUD.
  - Inputs: clk, rst_n, run.
  - Outputs: cnt, and tick (high when cnt==KBAUD-1).
  - Clears to 0 when run=0.
- Top level: FSM, shift register, data_cnt register.

## Test plan
- Reset sample: with rst_n low then released, tx=1, tx_ready=1, busy=0, baud_cnt_o=0 and data_cnt_o=15 while held and after release.
- Single byte, KBAUD=16: send 0xA5 -> tx low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16. Total 160 cycles; busy falls after cycle 160.
- Back-to-back 0x00 then 0xFF with tx_valid held: exactly 320 cycles. The second start bit begins the cycle after the first stop bit ends, with no high gap beyond one bit.
- Counter export, KBAUD=16: baud_cnt_o ramps 0..15 in every bit. data_cnt_o runs 8,0..7,9, then 15 in idle. The PWM diagnostic instance connected downstream produces the expected duty per bit.
- Reset mid-frame: assert rst_n low during data bit 3 of 0x3C -> tx=1 immediately. After release the line stays idle and no residual bits are sent.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 176 cycles (KBAUD=16), data_cnt_o=10 during the parity bit. Send 0x03 -> parity bit 0.
